mc_alu: RTL and testbench

//   Parametrised multicycle ALU for the MIPS multicycle core; successor to the single-cycle registered ALU.

---
 rtl/mc_alu.sv | 145 ++++++++++++++
 tb/tb_mc_alu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Multicycle MIPS ALU: single-cycle ops plus an iterative shift-add MULW, start/busy/done handshake.
// Optional ovf port and signed add/sub overflow detection when ALU_OVF_EN is defined.
module mc_alu #(
  parameter int DW    = 32,
  parameter int MUL_W = 16,
  parameter int SH_W  = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [SH_W-1:0] shamt,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   result,
  output logic            zero
`ifdef ALU_OVF_EN
  ,
  output logic            ovf
`endif
);

  localparam int PW = 2 * MUL_W;
  localparam int RW = (PW > DW) ? PW : DW;
  localparam int CW = $clog2(MUL_W + 1);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_MULW = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]      state;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_next;
  logic [MUL_W-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   sum;
  logic [DW-1:0]   diff;
  logic [DW-1:0]   alu_res;
  logic [SH_W-1:0] sh_eff;
  logic [RW-1:0]   prod_ext;

  assign busy     = (state == ST_MUL);
  assign sum      = a + b;
  assign diff     = a - b;
  assign sh_eff   = SH_W'(32'(shamt) % 32'(DW));
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign prod_ext = RW'(acc_next);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? DW'(1) : '0;
      OP_SLL:  alu_res = b << sh_eff;
      OP_SRL:  alu_res = b >> sh_eff;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_next;

  // Overflow when operands (after negating b for sub) agree in sign but the result does not.
  always_comb begin
    ovf_next = 1'b0;
    case (op)
      OP_ADD:  ovf_next = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      OP_SUB:  ovf_next = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      default: ovf_next = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`ifdef ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MULW) begin
              mcand  <= PW'(a[MUL_W-1:0]);
              mplier <= b[MUL_W-1:0];
              acc    <= '0;
              cnt    <= CW'(MUL_W);
              state  <= ST_MUL;
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              done   <= 1'b1;
`ifdef ALU_OVF_EN
              ovf    <= ovf_next;
`endif
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // Last iteration: publish the product taken straight from the adder output.
          if (cnt == CW'(1)) begin
            result <= prod_ext[DW-1:0];
            zero   <= (prod_ext[DW-1:0] == '0);
            done   <= 1'b1;
            state  <= ST_IDLE;
`ifdef ALU_OVF_EN
            ovf    <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Testbench for mc_alu: vector table of single-cycle ops, scoreboard of expected completions,
// and hand-written multiply, ignored-start, chained-start and mid-multiply reset sequences.
module tb_mc_alu;

  localparam int DW    = 32;
  localparam int MUL_W = 16;
  localparam int SH_W  = 5;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_MULW = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic            CLK = 1'b0;
  logic            RST;
  logic            start;
  logic [5:0]      op;
  logic [SH_W-1:0] shamt;
  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic            busy;
  logic            done;
  logic [DW-1:0]   result;
  logic            zero;
`ifdef ALU_OVF_EN
  logic            ovf;
`endif

  mc_alu #(.DW(DW), .MUL_W(MUL_W), .SH_W(SH_W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .op     (op),
    .shamt  (shamt),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
`ifdef ALU_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  typedef struct {
    logic [5:0]      op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [SH_W-1:0] shamt;
    logic [DW-1:0]   exp_res;
    logic            exp_ovf;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res;
    logic          ovf;
  } exp_t;

  localparam int NVEC = 17;
  vec_t v[NVEC];
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [5:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                                input logic [SH_W-1:0] s);
    op    = o;
    a     = x;
    b     = y;
    shamt = s;
    start = 1'b1;
  endtask

  // Every done pulse retires the oldest expected completion.
  always @(negedge CLK) begin
    if (RST === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("result", 64'(result), 64'(mon_e.res));
        check_output("zero", 64'(zero), 64'(mon_e.res == '0));
`ifdef ALU_OVF_EN
        check_output("ovf", 64'(ovf), 64'(mon_e.ovf));
`endif
      end
    end
  end

  task automatic run_mul(input logic [DW-1:0] ma, input logic [DW-1:0] mb, input logic [DW-1:0] expv,
                         input int inject_at, input bit chain, input string tag);
    logic [DW-1:0] held;
    int busy_cnt = 0;
    int done_j   = -1;
    int done_cnt = 0;
    bit held_ok  = 1'b1;
    held = result;
    apply_stimulus(OP_MULW, ma, mb, '0);
    sb.push_back('{expv, 1'b0});
    for (int j = 0; j < 40; j++) begin
      @(negedge CLK);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (result !== held) held_ok = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_j < 0) done_j = j;
      end
      if (j == inject_at) begin
        apply_stimulus(OP_ADD, 32'd7, 32'd7, '0);
      end else if (chain && done === 1'b1 && done_cnt == 1) begin
        apply_stimulus(OP_ADD, 32'd1, 32'd2, '0);
        sb.push_back('{32'd3, 1'b0});
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_output({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(MUL_W));
    check_output({tag, "_done_cycle"}, 64'(done_j), 64'(MUL_W));
    check_output({tag, "_done_count"}, 64'(done_cnt), chain ? 64'd2 : 64'd1);
    check_output({tag, "_result_held"}, 64'(held_ok), 64'd1);
  endtask

  initial begin
    int dcnt;
    v[0]  = '{OP_ADD,  32'h0000_0006, 32'h0000_0012, 5'd0,  32'h0000_0018, 1'b0};
    v[1]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0};
    v[2]  = '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 1'b0};
    v[3]  = '{OP_OR,   32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0};
    v[4]  = '{OP_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 5'd0,  32'h00FF_FF00, 1'b0};
    v[5]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0};
    v[6]  = '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b0};
    v[7]  = '{OP_SLL,  32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    v[8]  = '{OP_SRL,  32'h0000_0000, 32'h0000_0120, 5'd4,  32'h0000_0012, 1'b0};
    v[9]  = '{OP_SRL,  32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
    v[10] = '{OP_SLL,  32'h1234_5678, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
    v[11] = '{OP_BAD,  32'h1234_5678, 32'h9ABC_DEF0, 5'd3,  32'h0000_0000, 1'b0};
    v[12] = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0};
    v[13] = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0};
    v[14] = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1};
    v[15] = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1};
    v[16] = '{OP_AND,  32'h8000_0000, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0};

    RST = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(negedge CLK);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_result", 64'(result), 64'd0);
    check_output("reset_zero", 64'(zero), 64'd1);
`ifdef ALU_OVF_EN
    check_output("reset_ovf", 64'(ovf), 64'd0);
`endif
    RST = 1'b0;
    @(negedge CLK);

    // Single-cycle ops issued back to back, one per cycle.
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(v[i].op, v[i].a, v[i].b, v[i].shamt);
      sb.push_back('{v[i].exp_res, v[i].exp_ovf});
      @(negedge CLK);
      check_output($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      check_output($sformatf("vec%0d_done", i), 64'(done), 64'd1);
    end
    start = 1'b0;
    @(negedge CLK);
    check_output("done_pulse_end", 64'(done), 64'd0);

    run_mul(32'h0000_0012, 32'h0000_0010, 32'h0000_0120, -1, 1'b0, "mul_basic");
    run_mul(32'hABCD_FFFF, 32'h1234_FFFF, 32'hFFFE_0001, 5, 1'b0, "mul_trunc");
    run_mul(32'hFFFF_0003, 32'h0000_0005, 32'h0000_000F, -1, 1'b1, "mul_chain");

    // Reset during a multiply: nothing completes, and a fresh add is accepted right after.
    apply_stimulus(OP_MULW, 32'h0000_0012, 32'h0000_0010, '0);
    sb.push_back('{32'h0000_0120, 1'b0});
    for (int j = 0; j < 8; j++) begin
      @(negedge CLK);
      start = 1'b0;
      if (j == 7) begin
        RST = 1'b1;
        sb.delete();
      end
    end
    @(negedge CLK);
    RST = 1'b0;
    check_output("rst_mid_busy", 64'(busy), 64'd0);
    check_output("rst_mid_done", 64'(done), 64'd0);
    check_output("rst_mid_result", 64'(result), 64'd0);
    check_output("rst_mid_zero", 64'(zero), 64'd1);
    apply_stimulus(OP_ADD, 32'h0000_0006, 32'h0000_0012, '0);
    sb.push_back('{32'h0000_0018, 1'b0});
    @(negedge CLK);
    start = 1'b0;
    check_output("post_rst_add_done", 64'(done), 64'd1);
    dcnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (done === 1'b1) dcnt++;
    end
    check_output("post_rst_no_late_done", 64'(dcnt), 64'd0);
    check_output("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
